// File: rtl/unaligned_access_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : unaligned_access_sequencer
// Description : Splits byte-unaligned row-wide loads/stores into one or two
//               row-aligned RAM accesses, rotating store data / merging loads.
// Revision    : 1.0 - initial release
// ============================================================================
module unaligned_access_sequencer #(
    parameter int DATA_W = 128,
    parameter int ROW_AW = 19
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic                                   req_we,
    input  logic [ROW_AW+$clog2(DATA_W/8)-1:0]     req_addr,
    input  logic [DATA_W-1:0]                      req_wdata,
    output logic                                   resp_valid,
    input  logic                                   resp_ready,
    output logic [DATA_W-1:0]                      resp_rdata,
    output logic                                   mem_en,
    output logic                                   mem_we,
    output logic [ROW_AW-1:0]                      mem_addr,
    output logic [DATA_W/8-1:0]                    mem_be,
    output logic [DATA_W-1:0]                      mem_wdata,
    input  logic [DATA_W-1:0]                      mem_rdata
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFS_W = $clog2(BYTES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_RD_W = 3'd3,
        S_WR_A = 3'd4,
        S_WR_B = 3'd5,
        S_RESP = 3'd6
    } state_t;

    state_t              r_state_q, w_state_d;
    logic                r_we_q, w_we_d;
    logic [ROW_AW-1:0]   r_row_q, w_row_d;
    logic [OFS_W-1:0]    r_ofs_q, w_ofs_d;
    logic [DATA_W-1:0]   r_wdata_q, w_wdata_d;
    logic [DATA_W-1:0]   r_buf_a_q, w_buf_a_d;
    logic [DATA_W-1:0]   r_resp_rdata_q, w_resp_rdata_d;

    logic [BYTES-1:0]    w_hi_mask;
    logic [DATA_W-1:0]   w_hi_src;
    logic [DATA_W-1:0]   w_merge;
    logic [DATA_W-1:0]   w_sh_in;
    logic [OFS_W-1:0]    w_sh_amt;
    logic [2*DATA_W-1:0] w_sh_dbl;
    logic [DATA_W-1:0]   w_rot;
    logic [ROW_AW-1:0]   w_row_inc;

    // Bytes at or above the offset belong to the first row of the access.
    assign w_hi_mask = {BYTES{1'b1}} << r_ofs_q;
    assign w_hi_src  = (r_ofs_q == '0) ? mem_rdata : r_buf_a_q;
    assign w_row_inc = r_row_q + ROW_AW'(1);

    always_comb begin
        w_merge = '0;
        for (int k = 0; k < BYTES; k++) begin
            w_merge[k*8 +: 8] = w_hi_mask[k] ? w_hi_src[k*8 +: 8] : mem_rdata[k*8 +: 8];
        end
    end

    // Single left byte rotator shared by the store and load paths.
    assign w_sh_in  = r_we_q ? r_wdata_q : w_merge;
    assign w_sh_amt = r_we_q ? r_ofs_q : (OFS_W'(0) - r_ofs_q);
    assign w_sh_dbl = {w_sh_in, w_sh_in};
    assign w_rot    = DATA_W'((w_sh_dbl << {w_sh_amt, 3'b000}) >> DATA_W);

    always_comb begin
        w_state_d      = r_state_q;
        w_we_d         = r_we_q;
        w_row_d        = r_row_q;
        w_ofs_d        = r_ofs_q;
        w_wdata_d      = r_wdata_q;
        w_buf_a_d      = r_buf_a_q;
        w_resp_rdata_d = r_resp_rdata_q;
        case (r_state_q)
            S_IDLE: begin
                if (req_valid) begin
                    w_we_d    = req_we;
                    w_row_d   = req_addr[ROW_AW+OFS_W-1:OFS_W];
                    w_ofs_d   = req_addr[OFS_W-1:0];
                    w_wdata_d = req_wdata;
                    w_state_d = req_we ? S_WR_A : S_RD_A;
                end
            end
            S_RD_A: w_state_d = (r_ofs_q == '0) ? S_RD_W : S_RD_B;
            S_RD_B: begin
                w_buf_a_d = mem_rdata;
                w_state_d = S_RD_W;
            end
            S_RD_W: begin
                w_resp_rdata_d = w_rot;
                w_state_d      = S_RESP;
            end
            S_WR_A: begin
                w_resp_rdata_d = '0;
                w_state_d      = (r_ofs_q == '0) ? S_RESP : S_WR_B;
            end
            S_WR_B: begin
                w_resp_rdata_d = '0;
                w_state_d      = S_RESP;
            end
            S_RESP: if (resp_ready) w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= S_IDLE;
            r_we_q         <= 1'b0;
            r_row_q        <= '0;
            r_ofs_q        <= '0;
            r_wdata_q      <= '0;
            r_buf_a_q      <= '0;
            r_resp_rdata_q <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_we_q         <= w_we_d;
            r_row_q        <= w_row_d;
            r_ofs_q        <= w_ofs_d;
            r_wdata_q      <= w_wdata_d;
            r_buf_a_q      <= w_buf_a_d;
            r_resp_rdata_q <= w_resp_rdata_d;
        end
    end

    assign req_ready  = (r_state_q == S_IDLE);
    assign resp_valid = (r_state_q == S_RESP);
    assign resp_rdata = r_resp_rdata_q;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        case (r_state_q)
            S_RD_A: begin
                mem_en   = 1'b1;
                mem_addr = r_row_q;
            end
            S_RD_B: begin
                mem_en   = 1'b1;
                mem_addr = w_row_inc;
            end
            S_WR_A: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_row_q;
                mem_be    = w_hi_mask;
                mem_wdata = w_rot;
            end
            S_WR_B: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = w_row_inc;
                mem_be    = ~w_hi_mask;
                mem_wdata = w_rot;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
